// File: rtl/uart_tx_pkg.sv
// Shared definitions for the buffered UART transmit scheduler.
// Contents:
//   tx_state_e   transmit FSM state (IDLE -> SEND -> GAP -> IDLE)
//   STAT_*       bit positions in the status word
//   CTRL_*       bit positions in a control-word write
//   status_word  packs count and flags into the 32-bit status word
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int STAT_FULL    = 9;
  localparam int STAT_BUSY    = 10;
  localparam int STAT_OVF     = 11;
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_OVF_CLR = 11;

  // Bits not named here read as zero.
  function automatic logic [31:0] status_word(input logic [8:0] cnt,
                                              input logic full,
                                              input logic busy,
                                              input logic ovf);
    logic [31:0] w;
    w            = 32'd0;
    w[8:0]       = cnt;
    w[STAT_FULL] = full;
    w[STAT_BUSY] = busy;
    w[STAT_OVF]  = ovf;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// CPU IO page and UART byte-stream signals of the transmit scheduler.
// Signals:
//   io_wordaddr  IO word address, one-hot decoded
//   io_wdata     IO write data
//   io_wr        IO write strobe
//   io_rdata     status read data
//   uart_data    byte toward the UART
//   uart_valid   byte valid toward the UART
//   uart_ready   UART accepts a byte
// Modports: slave = the scheduler, master = CPU side plus UART model.
interface uart_tx_sched_if;
  logic [13:0] io_wordaddr;
  logic [31:0] io_wdata;
  logic        io_wr;
  logic [31:0] io_rdata;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready;

  modport slave (
    input  io_wordaddr, io_wdata, io_wr, uart_ready,
    output io_rdata, uart_data, uart_valid
  );

  modport master (
    output io_wordaddr, io_wdata, io_wr, uart_ready,
    input  io_rdata, uart_data, uart_valid
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered pointers and occupancy count.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   push, din    write a byte (ignored when full)
//   pop, dout    dout is the head entry; pop advances it (ignored when empty)
//   flush        empties the FIFO, has priority over push/pop
//   count        occupancy, 0..DEPTH
//   full, empty  derived from the registered count
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; count is one bit wider to reach DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Buffered transmit controller between the CPU IO page and a UART.
// Byte writes to the data word are queued; an FSM drains the queue into the
// UART with valid/ready and inserts one idle cycle after each byte.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   bus          uart_tx_sched_if.slave (IO decode, status read, UART stream)
// Parameters: DEPTH (FIFO entries), DAT_BIT / CNTL_BIT (one-hot address bits).
module uart_tx_sched
  import uart_tx_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DAT_BIT  = 1,
  parameter int CNTL_BIT = 2
) (
  input  logic           clk,
  input  logic           resetn,
  uart_tx_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  tx_state_e   state_r;
  tx_state_e   state_nxt_s;
  logic [7:0]  data_r;
  logic        ovf_r;
  logic        dat_sel_s;
  logic        cntl_sel_s;
  logic        push_s;
  logic        ctl_wr_s;
  logic        flush_s;
  logic        ovf_clr_s;
  logic        pop_s;
  logic [7:0]  fifo_dout_s;
  logic [AW:0] fifo_count_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        busy_s;
  logic [31:0] rdata_s;
  logic        unused_ok_s;

  // An address with both select bits set decodes to neither word.
  assign dat_sel_s  = bus.io_wordaddr[DAT_BIT] & ~bus.io_wordaddr[CNTL_BIT];
  assign cntl_sel_s = bus.io_wordaddr[CNTL_BIT] & ~bus.io_wordaddr[DAT_BIT];
  assign push_s     = bus.io_wr & dat_sel_s;
  assign ctl_wr_s   = bus.io_wr & cntl_sel_s;
  assign flush_s    = ctl_wr_s & bus.io_wdata[CTRL_FLUSH];
  assign ovf_clr_s  = ctl_wr_s & bus.io_wdata[CTRL_OVF_CLR];
  assign unused_ok_s = ^{bus.io_wdata, bus.io_wordaddr};

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_s),
    .pop    (pop_s),
    .flush  (flush_s),
    .din    (bus.io_wdata[7:0]),
    .dout   (fifo_dout_s),
    .count  (fifo_count_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  // Transmit state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_nxt_s;
  end

  // Next state and FIFO pop; GAP keeps valid low one cycle after a handshake.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (bus.uart_ready) state_nxt_s = GAP;
        else                state_nxt_s = SEND;
      end
      GAP:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output byte is captured only on the IDLE->SEND pop and held otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    data_r <= 8'd0;
    else if (pop_s) data_r <= fifo_dout_s;
    else            data_r <= data_r;
  end

  // Sticky overflow: a push into a full FIFO (pre-pop count) is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     ovf_r <= 1'b0;
    else if (push_s && fifo_full_s)  ovf_r <= 1'b1;
    else if (ovf_clr_s)              ovf_r <= 1'b0;
    else                             ovf_r <= ovf_r;
  end

  assign busy_s = ~fifo_empty_s | (state_r != IDLE);

  // Status read mux; any address carrying the control bit returns status.
  always_comb begin
    rdata_s = 32'd0;
    if (bus.io_wordaddr[CNTL_BIT]) begin
      rdata_s = status_word(9'(fifo_count_s), fifo_full_s, busy_s, ovf_r);
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.io_rdata   = rdata_s;
  assign bus.uart_data  = data_r;
  assign bus.uart_valid = (state_r == SEND);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus a random
// phase, all compared against a queue-based model of the transmit scheduler.
module tb_uart_tx_sched;
  localparam int DEPTH = 16;
  localparam logic [13:0] A_DAT   = 14'h0002;
  localparam logic [13:0] A_CNTL  = 14'h0004;
  localparam logic [13:0] A_BOTH  = 14'h0006;
  localparam logic [13:0] A_OTHER = 14'h0020;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  uart_tx_sched_if bus_if ();

  uart_tx_sched #(.DEPTH(DEPTH), .DAT_BIT(1), .CNTL_BIT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued bytes, byte on the wire, one-cycle gap, overflow.
  logic [7:0] q[$];
  bit         m_send;
  bit         m_gap;
  bit         m_ovf;
  logic [7:0] m_data;

  task automatic model_reset();
    q.delete();
    m_send = 1'b0;
    m_gap  = 1'b0;
    m_ovf  = 1'b0;
    m_data = 8'd0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    bit busy;
    busy    = (q.size() > 0) || m_send || m_gap;
    s       = 32'd0;
    s[8:0]  = 9'(q.size());
    s[9]    = (q.size() == DEPTH);
    s[10]   = busy;
    s[11]   = m_ovf;
    return s;
  endfunction

  // One clock edge of model behaviour, using pre-edge state for all decisions.
  task automatic model_step(input logic wr, input logic [13:0] addr,
                            input logic [31:0] wd, input logic rdy);
    bit dat;
    bit ctl;
    bit full_pre;
    dat      = wr && addr[1] && !addr[2];
    ctl      = wr && addr[2] && !addr[1];
    full_pre = (q.size() == DEPTH);
    if (m_send) begin
      if (rdy) begin
        m_send = 1'b0;
        m_gap  = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (q.size() > 0) begin
      m_data = q.pop_front();
      m_send = 1'b1;
    end
    if (dat) begin
      if (full_pre) m_ovf = 1'b1;
      else          q.push_back(wd[7:0]);
    end
    if (ctl && wd[0])  q.delete();
    if (ctl && wd[11]) m_ovf = 1'b0;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Starts at a negedge: apply inputs, check status read, clock, check stream.
  task automatic drive_cycle(input logic wr, input logic [13:0] addr,
                             input logic [31:0] wd, input logic rdy);
    bus_if.io_wr       = wr;
    bus_if.io_wordaddr = addr;
    bus_if.io_wdata    = wd;
    bus_if.uart_ready  = rdy;
    #1;
    check_eq("rdata", bus_if.io_rdata, addr[2] ? m_status() : 32'd0);
    @(posedge clk);
    model_step(wr, addr, wd, rdy);
    @(negedge clk);
    check_eq("valid", 32'(bus_if.uart_valid), 32'(m_send));
    check_eq("data", 32'(bus_if.uart_data), 32'(m_data));
  endtask

  task automatic peek(input string tag, input logic [13:0] addr,
                      input logic [31:0] exp);
    bus_if.io_wr       = 1'b0;
    bus_if.io_wordaddr = addr;
    #1;
    check_eq(tag, bus_if.io_rdata, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus_if.io_wr       = 1'b0;
    bus_if.io_wordaddr = 14'd0;
    bus_if.io_wdata    = 32'd0;
    bus_if.uart_ready  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    check_eq("rst_valid", 32'(bus_if.uart_valid), 32'd0);
    check_eq("rst_data", 32'(bus_if.uart_data), 32'd0);
    peek("rst_status", A_CNTL, 32'd0);

    // Single byte: latency N+2, stalled SEND, one-cycle GAP
    drive_cycle(1'b1, A_DAT, 32'h41, 1'b0);
    check_eq("lat_n1_valid", 32'(bus_if.uart_valid), 32'd0);
    drive_cycle(1'b0, A_OTHER, 32'd0, 1'b0);
    check_eq("lat_n2_valid", 32'(bus_if.uart_valid), 32'd1);
    check_eq("lat_n2_data", 32'(bus_if.uart_data), 32'h41);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, A_CNTL, 32'd0, 1'b0);
      check_eq("stall_valid", 32'(bus_if.uart_valid), 32'd1);
      check_eq("stall_data", 32'(bus_if.uart_data), 32'h41);
    end
    drive_cycle(1'b0, A_CNTL, 32'd0, 1'b1);
    check_eq("gap_valid", 32'(bus_if.uart_valid), 32'd0);
    peek("gap_busy", A_CNTL, 32'h400);
    drive_cycle(1'b0, A_CNTL, 32'd0, 1'b0);
    peek("back_idle", A_CNTL, 32'd0);

    // Burst of 18 with UART stalled: fills to 16, last write overflows
    for (int i = 0; i < 18; i++) drive_cycle(1'b1, A_DAT, 32'(i), 1'b0);
    peek("burst_full", A_CNTL, 32'hE10);
    drive_cycle(1'b1, A_BOTH, 32'hFFFF_FFFF, 1'b0);
    peek("illegal_wr", A_BOTH, 32'hE10);
    peek("nonctl_read", A_OTHER, 32'd0);
    for (int i = 0; i < 60; i++) drive_cycle(1'b0, A_CNTL, 32'd0, 1'b1);

    // Overflow clear, then flush with one byte in flight
    drive_cycle(1'b1, A_CNTL, 32'h800, 1'b0);
    peek("ovf_clr", A_CNTL, 32'd0);
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, A_DAT, 32'hA0 + 32'(i), 1'b0);
    peek("pre_flush", A_CNTL, 32'h405);
    drive_cycle(1'b1, A_CNTL, 32'h1, 1'b0);
    peek("post_flush", A_CNTL, 32'h400);
    check_eq("inflight_data", 32'(bus_if.uart_data), 32'hA0);
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, A_CNTL, 32'd0, 1'b1);
    peek("flush_done", A_CNTL, 32'd0);

    // Push coincident with IDLE pop at count 1
    drive_cycle(1'b1, A_DAT, 32'h55, 1'b0);
    drive_cycle(1'b1, A_DAT, 32'h66, 1'b0);
    peek("push_pop", A_CNTL, 32'h401);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, A_CNTL, 32'd0, 1'b1);

    // Reset mid-SEND, then latency again
    drive_cycle(1'b1, A_DAT, 32'h77, 1'b0);
    drive_cycle(1'b0, A_OTHER, 32'd0, 1'b0);
    check_eq("pre_rst_valid", 32'(bus_if.uart_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(bus_if.uart_valid), 32'd0);
    check_eq("rst_async_data", 32'(bus_if.uart_data), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    peek("rst_status2", A_CNTL, 32'd0);
    drive_cycle(1'b1, A_DAT, 32'h9A, 1'b0);
    drive_cycle(1'b0, A_OTHER, 32'd0, 1'b0);
    check_eq("rst_lat_valid", 32'(bus_if.uart_valid), 32'd1);
    check_eq("rst_lat_data", 32'(bus_if.uart_data), 32'h9A);

    // Random traffic: wraps pointers many times, random ready pacing
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [31:0] wd;
      logic rdy;
      sel = int'($urandom_range(0, 19));
      rdy = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if (sel < 9) begin
        drive_cycle(1'b1, A_DAT, wd, rdy);
      end else if (sel == 9) begin
        wd = 32'd0;
        wd[0]  = ($urandom_range(0, 3) == 0);
        wd[11] = 1'($urandom_range(0, 1));
        drive_cycle(1'b1, A_CNTL, wd, rdy);
      end else if (sel == 10) begin
        drive_cycle(1'b1, A_BOTH, wd, rdy);
      end else if (sel == 11) begin
        drive_cycle(1'b1, A_OTHER, wd, rdy);
      end else begin
        drive_cycle(1'b0, A_CNTL, wd, rdy);
      end
    end
    for (int i = 0; i < 60; i++) drive_cycle(1'b0, A_CNTL, 32'd0, 1'b1);
    peek("final_idle", A_CNTL, 32'(m_ovf) << 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
